// File: rtl/circ_idx_alloc_if.sv
// Request/response bundle between rename/retire logic and the circular index allocator.
// The master drives requests and the slave (the allocator) returns pointers and occupancy.
interface circ_idx_alloc_if #(
  parameter int SIZE        = 64,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4
);
  localparam int IW  = $clog2(SIZE);
  localparam int PW  = IW + 1;
  localparam int CW  = $clog2(SIZE + 1);
  localparam int FNW = $clog2(FREE_WIDTH + 1);

  logic [ALLOC_WIDTH-1:0]         i_alloc_req;
  logic                           o_can_alloc;
  logic [ALLOC_WIDTH-1:0][PW-1:0] o_alloc_idx;
  logic [FNW-1:0]                 i_free_num;
  logic                           i_squash_vld;
  logic [PW-1:0]                  i_squash_idx;
  logic [PW-1:0]                  o_head;
  logic [PW-1:0]                  o_tail;
  logic [CW-1:0]                  o_count;
  logic                           o_empty;
  logic                           o_full;

  modport master (
    output i_alloc_req, i_free_num, i_squash_vld, i_squash_idx,
    input  o_can_alloc, o_alloc_idx, o_head, o_tail, o_count, o_empty, o_full
  );

  modport slave (
    input  i_alloc_req, i_free_num, i_squash_vld, i_squash_idx,
    output o_can_alloc, o_alloc_idx, o_head, o_tail, o_count, o_empty, o_full
  );
endinterface

// File: rtl/circ_idx_alloc.sv
// Circular {flipped, idx} allocator for age-ordered buffers of arbitrary SIZE:
// multi-lane alloc at the tail, in-order free at the head, squash rolls the tail back.
module circ_idx_alloc #(
  parameter int SIZE        = 64,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  circ_idx_alloc_if.slave   bus
);
  localparam int IW = $clog2(SIZE);
  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW:0] SIZE_S = (CW+1)'(SIZE);
  localparam logic [CW:0] AW_S   = (CW+1)'(ALLOC_WIDTH);

  typedef struct packed {
    logic          flip;
    logic [IW-1:0] idx;
  } ptr_t;

  // Wrap at SIZE rather than at a power of two; k never exceeds SIZE so one subtract suffices.
  function automatic ptr_t ptr_add(input ptr_t p, input logic [CW-1:0] k);
    logic [CW:0] s;
    ptr_t        r;
    s = (CW+1)'(p.idx) + (CW+1)'(k);
    if (s >= SIZE_S) begin
      r.flip = ~p.flip;
      r.idx  = IW'(s - SIZE_S);
    end else begin
      r.flip = p.flip;
      r.idx  = IW'(s);
    end
    return r;
  endfunction

  // Age distance from a to b (b is younger or equal).
  function automatic logic [CW-1:0] ptr_dist(input ptr_t a, input ptr_t b);
    if (a.flip == b.flip) return CW'((CW+1)'(b.idx) - (CW+1)'(a.idx));
    else                  return CW'(SIZE_S - (CW+1)'(a.idx) + (CW+1)'(b.idx));
  endfunction

  ptr_t head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count;
  logic          can_alloc;
  logic [ALLOC_WIDTH:0][CW-1:0] pre;

  assign count     = ptr_dist(head_q, tail_q);
  assign can_alloc = (SIZE_S - (CW+1)'(count)) >= AW_S;

  // Exclusive prefix popcount of the request mask gives each lane its offset from tail.
  always_comb begin
    pre[0] = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++)
      pre[i+1] = pre[i] + CW'(bus.i_alloc_req[i]);
  end

  for (genvar g = 0; g < ALLOC_WIDTH; g++) begin : g_lane
    assign bus.o_alloc_idx[g] = ptr_add(tail_q, pre[g]);
  end

  always_comb begin
    head_d = ptr_add(head_q, CW'(bus.i_free_num));
    tail_d = tail_q;
    if (bus.i_squash_vld)
      tail_d = bus.i_squash_idx;
    else if (can_alloc && |bus.i_alloc_req)
      tail_d = ptr_add(tail_q, pre[ALLOC_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign bus.o_head      = head_q;
  assign bus.o_tail      = tail_q;
  assign bus.o_count     = count;
  assign bus.o_empty     = (count == '0);
  assign bus.o_full      = ((CW+1)'(count) == SIZE_S);
  assign bus.o_can_alloc = can_alloc;

  // Squash target must sit between the post-free head and the current tail in age order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (CW'(bus.i_free_num) <= count)
        else $error("circ_idx_alloc: free of %0d exceeds count %0d", bus.i_free_num, count);
      if (bus.i_squash_vld)
        assert (ptr_dist(head_d, bus.i_squash_idx) <= ptr_dist(head_d, tail_q))
          else $error("circ_idx_alloc: squash index %0h outside live range", bus.i_squash_idx);
    end
  end
endmodule

// File: tb/tb_circ_idx_alloc.sv
// Directed bench for circ_idx_alloc at SIZE=40: wrap, sparse lanes, full, squash, reset.
module tb_circ_idx_alloc;
  localparam int SIZE = 40;
  localparam int AW   = 4;
  localparam int FW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  circ_idx_alloc_if #(.SIZE(SIZE), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW)) bus ();

  circ_idx_alloc #(.SIZE(SIZE), .ALLOC_WIDTH(AW), .FREE_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] P(input int f, input int i);
    logic [5:0] iv;
    iv = 6'(i);
    return {f[0], iv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic [3:0] req, input int fnum, input logic sqv, input logic [6:0] sqi);
    bus.i_alloc_req  = req;
    bus.i_free_num   = 3'(fnum);
    bus.i_squash_vld = sqv;
    bus.i_squash_idx = sqi;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic state(input string tag, input logic [6:0] h, input logic [6:0] t, input int cnt);
    chk({tag, ".head"},  32'(bus.o_head),      32'(h));
    chk({tag, ".tail"},  32'(bus.o_tail),      32'(t));
    chk({tag, ".count"}, 32'(bus.o_count),     32'(cnt));
    chk({tag, ".empty"}, 32'(bus.o_empty),     32'(cnt == 0));
    chk({tag, ".full"},  32'(bus.o_full),      32'(cnt == SIZE));
    chk({tag, ".can"},   32'(bus.o_can_alloc), 32'((SIZE - cnt) >= AW));
  endtask

  initial begin
    rst = 1'b1;
    drive(4'h0, 0, 1'b0, 7'h0);
    cyc();
    cyc();
    rst = 1'b0;
    state("reset", P(0, 0), P(0, 0), 0);

    // Nine back-to-back full-width allocations
    for (int k = 0; k < 9; k++) begin
      drive(4'hF, 0, 1'b0, 7'h0);
      #1;
      if (k == 0) begin
        chk("first.l0", 32'(bus.o_alloc_idx[0]), 32'(P(0, 0)));
        chk("first.l3", 32'(bus.o_alloc_idx[3]), 32'(P(0, 3)));
      end
      if (k == 8) chk("ninth.l0", 32'(bus.o_alloc_idx[0]), 32'(P(0, 32)));
      cyc();
    end
    state("alloc9", P(0, 0), P(0, 36), 36);

    drive(4'h0, 2, 1'b0, 7'h0); cyc();
    state("free2", P(0, 2), P(0, 36), 34);

    drive(4'hF, 0, 1'b0, 7'h0);
    #1;
    chk("wrap.l0", 32'(bus.o_alloc_idx[0]), 32'(P(0, 36)));
    chk("wrap.l1", 32'(bus.o_alloc_idx[1]), 32'(P(0, 37)));
    chk("wrap.l2", 32'(bus.o_alloc_idx[2]), 32'(P(0, 38)));
    chk("wrap.l3", 32'(bus.o_alloc_idx[3]), 32'(P(0, 39)));
    cyc();
    state("wrap", P(0, 2), P(1, 0), 38);

    drive(4'hF, 0, 1'b0, 7'h0); cyc();
    state("blocked38", P(0, 2), P(1, 0), 38);

    drive(4'h0, 2, 1'b0, 7'h0); cyc();
    state("free2b", P(0, 4), P(1, 0), 36);

    drive(4'hF, 0, 1'b0, 7'h0); cyc();
    state("full", P(0, 4), P(1, 4), 40);

    drive(4'hF, 0, 1'b0, 7'h0); cyc();
    state("fullhold", P(0, 4), P(1, 4), 40);

    // Freed slots are not credited in the same cycle, so the request is dropped
    drive(4'hF, 4, 1'b0, 7'h0); cyc();
    state("fullfree", P(0, 8), P(1, 4), 36);

    // Reset in mid-operation discards a concurrent alloc and free
    rst = 1'b1;
    drive(4'hF, 1, 1'b0, 7'h0);
    cyc();
    rst = 1'b0;
    state("midreset", P(0, 0), P(0, 0), 0);

    drive(4'hF, 0, 1'b0, 7'h0); cyc();
    drive(4'hF, 0, 1'b0, 7'h0); cyc();
    drive(4'b0011, 0, 1'b0, 7'h0); cyc();
    state("pre_sparse", P(0, 0), P(0, 10), 10);

    drive(4'b1010, 0, 1'b0, 7'h0);
    #1;
    chk("sparse.l1", 32'(bus.o_alloc_idx[1]), 32'(P(0, 10)));
    chk("sparse.l3", 32'(bus.o_alloc_idx[3]), 32'(P(0, 11)));
    cyc();
    state("sparse", P(0, 0), P(0, 12), 12);

    drive(4'hF, 4, 1'b0, 7'h0); cyc();
    drive(4'hF, 1, 1'b0, 7'h0); cyc();
    state("allocfree", P(0, 5), P(0, 20), 15);
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 0, 1'b0, 7'h0); cyc();
    end
    drive(4'b0111, 0, 1'b0, 7'h0); cyc();
    state("pre_squash", P(0, 5), P(1, 3), 38);

    drive(4'b0111, 2, 1'b1, P(0, 30)); cyc();
    state("squash", P(0, 7), P(0, 30), 23);

    // Squash to the current tail is a no-op and still beats a legal alloc
    drive(4'hF, 0, 1'b1, P(0, 30)); cyc();
    state("squashnop", P(0, 7), P(0, 30), 23);

    drive(4'hF, 3, 1'b0, 7'h0); cyc();
    state("allocfree2", P(0, 10), P(0, 34), 24);

    drive(4'h0, 0, 1'b0, 7'h0);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
